// File: rtl/fm_disc_pkg.sv
// Shared constants and helpers for the FM discriminator: default widths, ADC channel
// codes, offset-binary <-> two's-complement conversion and signed saturation.
package fm_disc_pkg;

  localparam int         W_DEF        = 10;
  localparam int         AVG_LOG2_DEF = 3;
  localparam logic [2:0] CH_I         = 3'b110;
  localparam logic [2:0] CH_Q         = 3'b100;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_res_t;

  // Offset-binary and two's complement differ only in the MSB of a w-bit word.
  function automatic logic [31:0] ob2s(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction

  function automatic logic [31:0] s2ob(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction

  function automatic sat_res_t sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.sat = (x > hi) || (x < lo);
    if (x > hi)      r.val = hi[31:0];
    else if (x < lo) r.val = lo[31:0];
    else             r.val = x[31:0];
    return r;
  endfunction

endpackage

// File: rtl/fm_discriminator_boxcar.sv
// Boxcar averager / decimator over 2^AVG_LOG2 samples, with a pass-through bypass mode.
module boxcar_decimator
  import fm_disc_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic signed [W-1:0] s,
  input  logic                s_sat,
  input  logic                s_valid,
  input  logic                bypass,
  input  logic                clear,
  output logic signed [W-1:0] a,
  output logic                a_sat,
  output logic                a_valid
);

  localparam int AW = W + AVG_LOG2;

  logic signed [AW-1:0]       acc_reg;
  logic        [AVG_LOG2-1:0] cnt_reg;
  logic                       sat_acc_reg;
  logic signed [AW-1:0]       s_ext;
  logic signed [AW-1:0]       sum_next;

  assign s_ext    = {{AVG_LOG2{s[W-1]}}, s};
  assign sum_next = acc_reg + s_ext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sat_acc_reg <= 1'b0;
      a           <= '0;
      a_sat       <= 1'b0;
      a_valid     <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      if (bypass) begin
        acc_reg     <= '0;
        cnt_reg     <= '0;
        sat_acc_reg <= 1'b0;
        if (s_valid) begin
          a       <= s;
          a_sat   <= s_sat;
          a_valid <= 1'b1;
        end
      end else if (clear) begin
        acc_reg     <= '0;
        cnt_reg     <= '0;
        sat_acc_reg <= 1'b0;
      end else if (s_valid) begin
        if (cnt_reg == '1) begin
          // Dropping the low bits of the two's-complement sum is a floor divide.
          a           <= sum_next[AW-1:AVG_LOG2];
          a_sat       <= sat_acc_reg | s_sat;
          a_valid     <= 1'b1;
          acc_reg     <= '0;
          cnt_reg     <= '0;
          sat_acc_reg <= 1'b0;
        end else begin
          acc_reg     <= sum_next;
          cnt_reg     <= cnt_reg + 1'b1;
          sat_acc_reg <= sat_acc_reg | s_sat;
        end
      end
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// FM quadrature discriminator: pairs I/Q ADC samples by channel code, forms the
// cross-product phase difference, scales/saturates it and optionally averages.
module fm_discriminator
  import fm_disc_pkg::*;
#(
  parameter int         W        = W_DEF,
  parameter int         AVG_LOG2 = AVG_LOG2_DEF,
  parameter logic [2:0] I_CH     = CH_I,
  parameter logic [2:0] Q_CH     = CH_Q
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [2:0]   channel,
  input  logic [W-1:0] sample,
  input  logic [3:0]   gain_shift,
  input  logic         avg_bypass,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         sat,
  output logic         pair_err
);

  logic [31:0]         smp_s32;
  logic signed [W-1:0] smp_s;
  logic                is_i, is_q;

  assign smp_s32 = ob2s({{(32-W){1'b0}}, sample}, W);
  assign smp_s   = smp_s32[W-1:0];
  assign is_i    = en && (channel == I_CH);
  assign is_q    = en && (channel == Q_CH);

  logic                i_pend_reg, primed_reg, pair_err_reg;
  logic signed [W-1:0] i_cur_reg, i_prev_reg, q_prev_reg;
  logic                s1_valid_reg;
  logic signed [W-1:0] s1_i_reg, s1_q_reg, s1_ip_reg, s1_qp_reg;

  // Pairing front end; s1_* holds the new pair alongside the history it is compared with.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_pend_reg   <= 1'b0;
      primed_reg   <= 1'b0;
      pair_err_reg <= 1'b0;
      i_cur_reg    <= '0;
      i_prev_reg   <= '0;
      q_prev_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_i_reg     <= '0;
      s1_q_reg     <= '0;
      s1_ip_reg    <= '0;
      s1_qp_reg    <= '0;
    end else begin
      pair_err_reg <= (is_i && i_pend_reg) || (is_q && !i_pend_reg);
      s1_valid_reg <= 1'b0;
      if (is_i) begin
        i_cur_reg  <= smp_s;
        i_pend_reg <= 1'b1;
      end else if (is_q && i_pend_reg) begin
        i_pend_reg   <= 1'b0;
        primed_reg   <= 1'b1;
        s1_valid_reg <= primed_reg;
        s1_i_reg     <= i_cur_reg;
        s1_q_reg     <= smp_s;
        s1_ip_reg    <= i_prev_reg;
        s1_qp_reg    <= q_prev_reg;
        i_prev_reg   <= i_cur_reg;
        q_prev_reg   <= smp_s;
      end
    end
  end

  logic                  s2_valid_reg, s3_valid_reg, s4_valid_reg, s4_sat_reg;
  logic signed [2*W-1:0] p1_reg, p2_reg;
  logic signed [2*W:0]   d_reg;
  logic signed [W-1:0]   s4_reg;
  logic signed [63:0]    d_ext, d_shift;
  sat_res_t              s4_res;

  assign d_ext   = {{(63-2*W){d_reg[2*W]}}, d_reg};
  assign d_shift = d_ext >>> gain_shift;
  assign s4_res  = sat_w(d_shift, W);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s4_valid_reg <= 1'b0;
      s4_sat_reg   <= 1'b0;
      p1_reg       <= '0;
      p2_reg       <= '0;
      d_reg        <= '0;
      s4_reg       <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      p1_reg       <= s1_i_reg * s1_qp_reg;
      p2_reg       <= s1_q_reg * s1_ip_reg;
      s3_valid_reg <= s2_valid_reg;
      d_reg        <= p2_reg - p1_reg;
      s4_valid_reg <= s3_valid_reg;
      s4_reg       <= s4_res.val[W-1:0];
      s4_sat_reg   <= s4_res.sat;
    end
  end

  logic                bypass_d_reg;
  logic signed [W-1:0] avg_a;
  logic                avg_sat, avg_valid;
  logic [31:0]         a_ob32;

  boxcar_decimator #(.W(W), .AVG_LOG2(AVG_LOG2)) u_boxcar (
    .clk     (clk),
    .rstn    (rstn),
    .s       (s4_reg),
    .s_sat   (s4_sat_reg),
    .s_valid (s4_valid_reg),
    .bypass  (avg_bypass),
    .clear   (avg_bypass != bypass_d_reg),
    .a       (avg_a),
    .a_sat   (avg_sat),
    .a_valid (avg_valid)
  );

  assign a_ob32 = s2ob({{(32-W){avg_a[W-1]}}, avg_a}, W);

  logic [W-1:0] out_reg;
  logic         out_valid_reg, sat_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bypass_d_reg  <= 1'b0;
      out_reg       <= {1'b1, {(W-1){1'b0}}};
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      bypass_d_reg  <= avg_bypass;
      out_valid_reg <= avg_valid;
      sat_reg       <= avg_valid && avg_sat;
      if (avg_valid) out_reg <= a_ob32[W-1:0];
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign sat       = sat_reg;
  assign pair_err  = pair_err_reg;

endmodule

// File: tb/tb_fm_discriminator.sv
// Randomised scoreboard bench for fm_discriminator: a behavioural model predicts
// every output word, saturation flag, pairing error and its arrival cycle.
module tb_fm_discriminator;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [2:0] channel = 3'd0;
  logic [9:0] sample = 10'd0;
  logic [3:0] gain_shift = 4'd0;
  logic       avg_bypass = 1'b1;
  logic [9:0] dout;
  logic       out_valid, sat, pair_err;

  fm_discriminator dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .channel    (channel),
    .sample     (sample),
    .gain_shift (gain_shift),
    .avg_bypass (avg_bypass),
    .out        (dout),
    .out_valid  (out_valid),
    .sat        (sat),
    .pair_err   (pair_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int out;
    int sat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  // Reference model state, phrased in terms of pairs and blocks of samples.
  int m_icur, m_ip, m_qp, m_gain;
  bit m_ipend, m_primed, m_bypass;
  int avg_s[$];
  bit avg_sat;

  function automatic int floor_div(input int d, input int div);
    int q;
    q = d / div;
    if (d < 0 && q * div != d) q--;
    return q;
  endfunction

  function automatic void model_clear();
    m_icur = 0; m_ip = 0; m_qp = 0;
    m_ipend = 0; m_primed = 0;
    avg_s.delete(); avg_sat = 0;
  endfunction

  function automatic void model_strobe(input logic [2:0] ch, input int v, input int c);
    int d, s, a, sum;
    bit st;
    exp_t e;
    if (ch == 3'b110) begin
      if (m_ipend) err_q.push_back(c + 1);
      m_icur  = v;
      m_ipend = 1;
    end else if (ch == 3'b100) begin
      if (!m_ipend) begin
        err_q.push_back(c + 1);
        return;
      end
      m_ipend = 0;
      if (m_primed) begin
        d  = v * m_ip - m_icur * m_qp;
        s  = floor_div(d, 1 << m_gain);
        st = (s > 511) || (s < -512);
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        if (m_bypass) begin
          e.out = s + 512; e.sat = st; e.cyc = c + 6;
          exp_q.push_back(e);
        end else begin
          avg_s.push_back(s);
          avg_sat = avg_sat | st;
          if (avg_s.size() == 8) begin
            sum = 0;
            foreach (avg_s[k]) sum += avg_s[k];
            a = floor_div(sum, 8);
            e.out = a + 512; e.sat = avg_sat; e.cyc = c + 6;
            exp_q.push_back(e);
            avg_s.delete();
            avg_sat = 0;
          end
        end
      end
      m_ip = m_icur;
      m_qp = v;
      m_primed = 1;
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (rstn) begin
      if (out_valid) begin
        $display("out   cyc=%0d out=%0d sat=%0d", cyc, dout, sat);
        chk("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_value", int'(dout), e.out);
          chk("out_sat", int'(sat), e.sat);
          chk("out_latency", cyc, e.cyc);
        end
      end
      if (pair_err) begin
        $display("perr  cyc=%0d", cyc);
        chk("perr_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          ec = err_q.pop_front();
          chk("perr_cycle", cyc, ec);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [2:0] ch, input int smp);
    int c;
    c       = cyc;
    en      = 1'b1;
    channel = ch;
    sample  = smp[9:0];
    model_strobe(ch, smp - 512, c);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic pair(input int i_s, input int q_s);
    strobe(3'b110, i_s);
    strobe(3'b100, q_s);
  endtask

  task automatic set_ctrl(input bit byp, input int g);
    idle(8);
    avg_bypass = byp;
    gain_shift = g[3:0];
    if (byp != m_bypass) begin
      avg_s.delete();
      avg_sat = 0;
    end
    m_bypass = byp;
    m_gain   = g;
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    exp_q.delete();
    err_q.delete();
    model_clear();
    repeat (2) begin
      @(negedge clk);
      chk("rst_out", int'(dout), 512);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_perr", int'(pair_err), 0);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_action();
    int r, ch;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      strobe(3'b110, $urandom_range(0, 1023));
      idle($urandom_range(0, 2));
      strobe(3'b100, $urandom_range(0, 1023));
    end else if (r == 7) begin
      strobe(3'b110, $urandom_range(0, 1023));
      strobe(3'b110, $urandom_range(0, 1023));
      strobe(3'b100, $urandom_range(0, 1023));
    end else if (r == 8) begin
      strobe(3'b100, $urandom_range(0, 1023));
    end else begin
      ch = $urandom_range(0, 7);
      if (ch == 6 || ch == 4) ch = 0;
      strobe(ch[2:0], $urandom_range(0, 1023));
    end
    idle($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    m_bypass = 1;
    m_gain   = 0;
    do_reset();

    // Constant phase: D = 0 for every pair after priming.
    set_ctrl(1, 0);
    repeat (4) pair(612, 612);

    // Unsaturated rotation, checked directly 5 edges after the Q strobe.
    do_reset();
    set_ctrl(1, 6);
    pair(612, 512);
    pair(512, 612);
    idle(5);
    chk("rot_valid", int'(out_valid), 1);
    chk("rot_out", int'(dout), 668);
    chk("rot_sat", int'(sat), 0);

    // Saturation both ways; history is (I=0,Q=100) from the rotation above.
    set_ctrl(1, 4);
    pair(612, 512);
    idle(5);
    chk("satn_out", int'(dout), 0);
    chk("satn_sat", int'(sat), 1);
    pair(512, 612);
    idle(5);
    chk("satp_out", int'(dout), 1023);
    chk("satp_sat", int'(sat), 1);

    // Pairing errors: lone Q, then a doubled I where the second one counts.
    set_ctrl(1, 6);
    strobe(3'b100, 700);
    idle(2);
    strobe(3'b110, 600);
    strobe(3'b110, 650);
    strobe(3'b100, 520);
    idle(3);

    // Reset with pairs in flight; the next pair only primes.
    pair(700, 300);
    pair(300, 700);
    do_reset();
    set_ctrl(1, 6);
    pair(612, 512);
    pair(512, 612);

    // Randomised traffic across averaging/bypass and gain settings.
    for (int blk = 0; blk < 10; blk++) begin
      set_ctrl((blk % 3) == 2, $urandom_range(3, 12));
      repeat (48) rand_action();
    end

    idle(20);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("perr_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_discriminator.md
# fm_discriminator

Parametrised FM quadrature discriminator for the SDR receive path. Pairs time-multiplexed I and Q samples from the ADC sequencer by channel code and removes the offset-binary bias. Computes the cross-product phase difference Q[n]·I[n−1] − I[n]·Q[n−1], scales and saturates it, then optionally boxcar-averages and decimates it. Audio comes out in offset-binary with a valid strobe, all in the `clk` domain with no derived clocks.

## Interface

Parameters:
- `W`, 10: sample and output width (bits)
- `AVG_LOG2`, 3: boxcar length and decimation factor, 2^AVG_LOG2; legal range 1..6
- `I_CH`, 3'b110: channel code carrying I
- `Q_CH`, 3'b100: channel code carrying Q

Ports. Reset is `rstn`, asynchronous, active-low; clock is `clk`.
- `clk`, in, 1: clock
- `rstn`, in, 1: async active-low reset
- `en`, in, 1: sample strobe; `sample`/`channel` valid this cycle
- `channel`, in, 3: ADC channel code of `sample`
- `sample`, in, W: offset-binary ADC sample
- `gain_shift`, in, 4: arithmetic right shift applied to the cross-product
- `avg_bypass`, in, 1: 1 = output every pair, no averaging
- `out`, out, W: offset-binary discriminator output
- `out_valid`, out, 1: one-cycle pulse, `out` updated
- `sat`, out, 1: pulse with `out_valid` if any contributing sample saturated
- `pair_err`, out, 1: one-cycle pulse on a pairing violation

## Operation

- **Bias removal.** The signed value is `sample` with MSB inverted, i.e. sample − 2^(W−1), W-bit two's complement.
- **I capture.** `en` with `channel==I_CH` latches I_cur and sets `i_pend`. If `i_pend` is already set, I_cur is overwritten and `pair_err` pulses.
- **Q capture.** `en` with `channel==Q_CH`:
  - With `i_pend`: the pair (I_cur, Q) is formed. History updates I_prev←I_new and Q_prev←Q_new (previous pair). `i_pend` clears.
  - Without `i_pend`: Q is discarded and `pair_err` pulses.
- **Other channels.** Other codes are ignored.
- **Priming.** The first pair after reset only loads history and produces no output.
- **Pipeline.** Fully pipelined with a valid tag per stage. It advances every cycle regardless of `en`.
  - S1: pair register.
  - S2: P1 = I_n·Q_{n−1}, P2 = Q_n·I_{n−1}, each 2W bits signed.
  - S3: D = P2 − P1, 2W+1 bits.
  - S4: S = D >>> `gain_shift`, saturated to W-bit signed [−2^(W−1), 2^(W−1)−1]. A saturation flag travels with S.
- **Averager.**
  - With `avg_bypass`=0: accumulate S into a signed (W+AVG_LOG2)-bit sum. On the 2^AVG_LOG2-th sample, output A = sum >>> AVG_LOG2 (floor), clear the sum and count, and pulse `out_valid`. `sat` is the OR of the block's saturation flags.
  - With `avg_bypass`=1: A = S for every pair.
- **Output.** `out` = A with MSB inverted. It holds between `out_valid` pulses.
- **Control changes.** A change of `avg_bypass` clears the accumulator and count; the partial block is dropped. `gain_shift` is sampled at S4 per sample.

## Timing

- **Reset values.** `out`=2^(W−1) (512 for W=10). `out_valid`=0, `sat`=0, `pair_err`=0. All history, `i_pend`, accumulator and count cleared. The primed flag is cleared.
- **Latency.** Q strobe accepted at edge t gives `out`/`out_valid` registered at edge t+5, for the completing sample when averaging.
- **Pairing error timing.** `pair_err` is registered one cycle after the offending strobe.
- **Throughput.** One pair per two cycles maximum; no backpressure.
- **Reset mid-operation.** Everything returns to reset values and the first subsequent pair is priming-only.

## Structure

- Package `fm_disc_pkg`: default `W`, `AVG_LOG2`, channel-code constants `CH_I`/`CH_Q`, and function `ob2s`/`s2ob` (offset-binary ↔ signed). The saturation helper `sat_w` also belongs here.
- Sub-module `boxcar_decimator`, parameters W and AVG_LOG2. It takes S plus the saturation flag and valid, a bypass input, and a clear input, and outputs A, the saturation flag and valid.

## Test plan

1. **Reset.** Assert `rstn` low mid-stream → `out`=512, `out_valid`=`sat`=`pair_err`=0. The next pair produces no output.
2. **Constant phase.** `avg_bypass`=1, `gain_shift`=0, repeated pairs I=612, Q=612 → every pair after priming gives D=0 → `out`=512, `sat`=0.
3. **Rotation, unsaturated.** `avg_bypass`=1, `gain_shift`=6, pair (612,512) then (512,612) → D=10000, S=156 → `out`=668 exactly 5 cycles after the Q strobe.
4. **Saturation.** Same pairs as scenario 3, `gain_shift`=4 → S clamps to 511 → `out`=1023, `sat`=1. The reverse rotation gives `out`=0 with `sat`=1.
5. **Averaging.** `avg_bypass`=0, AVG_LOG2=3; eight samples alternating S=100 and S=−20 → one `out_valid` per 8 pairs, `out`=552.
6. **Pairing errors.**
   - Q strobe with no pending I → `pair_err` pulse, no output, history unchanged.
   - Two I strobes before Q → `pair_err` pulse, and the second I is the one used.
